// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order pipeline registers (IF/ID, ID/EX, ...).
package pipe_pkg;

    // Default bus widths so every pipe register agrees on them unless overridden.
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_W    = 32;

    // Bubble instruction: sll $0,$0,0 encodes as all zeros.
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Occupancy of a two-entry elastic stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of an elastic pipe stage: a data word plus its valid bit.
// clear_i wins over load_i; load_i takes both data and valid from the inputs,
// so a slot can be rewritten as an invalid bubble while keeping chosen fields.
module pipe_entry #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Slot update: clear to the bubble value, or load a new word/valid pair.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= CLR_VAL;
        end else if (load_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// Fetch-to-decode pipeline register: two-entry elastic stage (main + skid)
// with valid/ready on both sides and a synchronous flush for branch squash.
// All outputs come straight from flops; there is no input-to-output path.
module if_id_pipe_reg
    import pipe_pkg::*;
#(
    parameter int                   INSTR_W   = DEF_INSTR_W,
    parameter int                   PC_W      = DEF_PC_W,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(MIPS_NOP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    npc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    npc_out
);

    localparam int              EW       = INSTR_W + PC_W;
    // Empty main slot shows the bubble instruction and a zero next-PC.
    localparam logic [EW-1:0]   MAIN_CLR = {NOP_INSTR, {PC_W{1'b0}}};

    logic              in_ready_q;
    logic              main_valid;
    logic [EW-1:0]     main_data;
    logic              skid_valid;
    logic [EW-1:0]     skid_data;

    logic              squash;
    logic              push;
    logic              pop;
    pipe_state_e       state_cur;
    pipe_state_e       state_d;
    logic              main_load_d;
    logic              main_valid_d;
    logic [EW-1:0]     main_data_d;
    logic              skid_load_d;
    logic              skid_clr_d;

    assign squash = rst | flush;
    assign push   = in_valid & in_ready_q;
    assign pop    = main_valid & out_ready;

    // Occupancy lives in the two valid bits; decode it for readability.
    always_comb begin
        state_cur = ST_EMPTY;
        if (skid_valid) begin
            state_cur = ST_FULL;
        end else if (main_valid) begin
            state_cur = ST_ONE;
        end
    end

    // Next-state and slot steering for push/pop; squash is applied in the slots.
    always_comb begin
        state_d      = state_cur;
        main_load_d  = 1'b0;
        main_valid_d = 1'b0;
        main_data_d  = {instr_in, npc_in};
        skid_load_d  = 1'b0;
        skid_clr_d   = 1'b0;
        case (state_cur)
            ST_EMPTY: begin
                if (push) begin
                    main_load_d  = 1'b1;
                    main_valid_d = 1'b1;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_load_d  = 1'b1;
                    main_valid_d = 1'b1;
                end else if (push) begin
                    skid_load_d  = 1'b1;
                    state_d      = ST_FULL;
                end else if (pop) begin
                    // Drain to a bubble: instruction becomes NOP, next-PC is kept.
                    main_load_d  = 1'b1;
                    main_valid_d = 1'b0;
                    main_data_d  = {NOP_INSTR, main_data[PC_W-1:0]};
                    state_d      = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can move the stage.
                if (pop) begin
                    main_load_d  = 1'b1;
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data;
                    skid_clr_d   = 1'b1;
                    state_d      = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Registered ready: low exactly when the skid slot will be occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else if (flush) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    pipe_entry #(
        .W       (EW),
        .CLR_VAL (MAIN_CLR)
    ) u_main (
        .clk     (clk),
        .clear_i (squash),
        .load_i  (main_load_d),
        .valid_i (main_valid_d),
        .data_i  (main_data_d),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    pipe_entry #(
        .W       (EW),
        .CLR_VAL ({EW{1'b0}})
    ) u_skid (
        .clk     (clk),
        .clear_i (squash | skid_clr_d),
        .load_i  (skid_load_d),
        .valid_i (1'b1),
        .data_i  ({instr_in, npc_in}),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign instr_out = main_data[EW-1:PC_W];
    assign npc_out   = main_data[PC_W-1:0];

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a default 32/32 instance and a 64/48 instance with a
// non-zero bubble pattern share one stimulus stream. The reference model is a
// bounded FIFO (capacity 2) of accepted beats; its head is what decode must see.
module tb_if_id_pipe_reg;

    localparam logic [63:0] WIDE_NOP = 64'hFFFF_0000_FFFF_0000;

    typedef struct packed {
        logic [63:0] instr;
        logic [47:0] npc;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] instr_w;
    logic [47:0] npc_w;

    logic        n_in_ready, n_out_valid;
    logic [31:0] n_instr, n_npc;
    logic        w_in_ready, w_out_valid;
    logic [63:0] w_instr;
    logic [47:0] w_npc;

    beat_t       sb_q[$];
    logic        exp_ready;
    logic [47:0] last_npc;
    logic        mon_en;
    int          total;
    int          bad;
    int          beats;

    if_id_pipe_reg u_n (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (n_in_ready),
        .instr_in  (instr_w[31:0]),
        .npc_in    (npc_w[31:0]),
        .out_valid (n_out_valid),
        .out_ready (out_ready),
        .instr_out (n_instr),
        .npc_out   (n_npc)
    );

    if_id_pipe_reg #(
        .INSTR_W   (64),
        .PC_W      (48),
        .NOP_INSTR (WIDE_NOP)
    ) u_w (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .instr_in  (instr_w),
        .npc_in    (npc_w),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .instr_out (w_instr),
        .npc_out   (w_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] wi(input logic [31:0] x);
        return {x ^ 32'h5A5A_C3C3, x};
    endfunction

    function automatic logic [47:0] wp(input logic [31:0] x);
        return {16'h0A0A, x};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then apply the FIFO rules for that edge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [63:0] ins, input logic [47:0] pc, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        instr_w   = ins;
        npc_w     = pc;
        out_ready = ordy;
        @(posedge clk);
        #1;
        if (r || f) begin
            sb_q.delete();
            last_npc = '0;
        end else if (iv && exp_ready) begin
            sb_q.push_back('{instr: ins, npc: pc});
        end
        if (sb_q.size() > 0) last_npc = sb_q[0].npc;
        exp_ready = (sb_q.size() < 2);
    endtask

    // Monitor: compare presented outputs with the FIFO head, retire consumed beats.
    initial begin
        beat_t       hd;
        logic        ev;
        logic [63:0] e_ins_w;
        logic [47:0] e_npc_w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ev = (sb_q.size() > 0);
                if (ev) begin
                    hd      = sb_q[0];
                    e_ins_w = hd.instr;
                    e_npc_w = hd.npc;
                end else begin
                    hd      = '0;
                    e_ins_w = WIDE_NOP;
                    e_npc_w = last_npc;
                end
                check("n_valid", {63'b0, n_out_valid}, {63'b0, ev});
                check("w_valid", {63'b0, w_out_valid}, {63'b0, ev});
                check("n_ready", {63'b0, n_in_ready}, {63'b0, exp_ready});
                check("w_ready", {63'b0, w_in_ready}, {63'b0, exp_ready});
                check("n_instr", {32'b0, n_instr}, ev ? {32'b0, e_ins_w[31:0]} : 64'h0);
                check("n_npc",   {32'b0, n_npc},   {32'b0, e_npc_w[31:0]});
                check("w_instr", w_instr, e_ins_w);
                check("w_npc",   {16'b0, w_npc},   {16'b0, e_npc_w});
                if (ev && out_ready && !rst && !flush) begin
                    beats = beats + 1;
                    $display("beat %0d: instr=%h npc=%h", beats, hd.instr, hd.npc);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [63:0] a_i, b_i, c_i, d_i, r_i;
        logic [47:0] a_p, b_p, c_p, d_p, r_p;
        logic        r, f, iv, ordy, fresh;
        total     = 0;
        bad       = 0;
        beats     = 0;
        mon_en    = 1'b0;
        exp_ready = 1'b1;
        last_npc  = '0;
        a_i = wi(32'h8C01_0004); a_p = wp(32'h04);
        b_i = wi(32'h2022_0001); b_p = wp(32'h08);
        c_i = wi(32'hAC02_0008); c_p = wp(32'h0C);
        d_i = wi(32'h1234_5678); d_p = wp(32'h10);

        // Reset held two cycles with a beat offered: nothing may get through.
        step(1'b1, 1'b0, 1'b1, a_i, a_p, 1'b1);
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b1, a_i, a_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, a_i, a_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, a_i, a_p, 1'b1);

        // Back-to-back streaming with decode always ready.
        step(1'b0, 1'b0, 1'b1, a_i, a_p, 1'b1);
        step(1'b0, 1'b0, 1'b1, b_i, b_p, 1'b1);
        step(1'b0, 1'b0, 1'b1, c_i, c_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, c_i, c_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, c_i, c_p, 1'b1);

        // Stall into the skid slot, hold C while full, then release.
        step(1'b0, 1'b0, 1'b1, a_i, a_p, 1'b0);
        step(1'b0, 1'b0, 1'b1, b_i, b_p, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, c_i, c_p, 1'b0);
        step(1'b0, 1'b0, 1'b1, c_i, c_p, 1'b1);
        step(1'b0, 1'b0, 1'b1, c_i, c_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, c_i, c_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, c_i, c_p, 1'b1);

        // Flush while full with a coincident push; the pushed beat must vanish.
        step(1'b0, 1'b0, 1'b1, a_i, a_p, 1'b0);
        step(1'b0, 1'b0, 1'b1, b_i, b_p, 1'b0);
        step(1'b0, 1'b1, 1'b1, d_i, d_p, 1'b0);
        step(1'b0, 1'b0, 1'b0, d_i, d_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, d_i, d_p, 1'b1);

        // Single beat drains to a bubble that keeps its next-PC.
        step(1'b0, 1'b0, 1'b1, a_i, a_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, a_i, a_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, a_i, a_p, 1'b1);

        // Random traffic; the producer holds its beat until it is accepted.
        fresh = 1'b1;
        r_i   = '0;
        r_p   = '0;
        for (int k = 0; k < 600; k++) begin
            if (fresh) begin
                r_i = {$urandom, $urandom};
                r_p = {16'($urandom), $urandom};
            end
            r    = ($urandom_range(0, 99) == 0);
            f    = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fresh = !iv || exp_ready || r || f;
            step(r, f, iv, r_i, r_p, ordy);
        end
        step(1'b0, 1'b0, 1'b0, r_i, r_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, r_i, r_p, 1'b1);
        step(1'b0, 1'b0, 1'b0, r_i, r_p, 1'b1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Clocked, parametrised Fetch-to-Decode pipeline register.
- Replaces the transparent IF/ID latch with an elastic 2-entry stage: valid/ready handshake on both sides, stall back-pressure via a skid entry, and synchronous flush for branch/jump squash.
- Sits between the fetch unit (producer) and the decode stage (consumer). Width-generic, so the same block serves wider instruction/PC buses.

Parameters:
- INSTR_W, 32, instruction word width.
- PC_W, 32, next-PC width.
- NOP_INSTR, 32'h0000_0000, bubble value driven on instr_out when the stage is empty. Width INSTR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all held entries; synchronous.
- in_valid  in  1  fetch presents a valid instr/npc pair.
- in_ready  out  1  stage can accept a beat; registered.
- instr_in  in  INSTR_W  fetched instruction.
- npc_in  in  PC_W  next PC from fetch.
- out_valid  out  1  instr_out/npc_out hold a valid beat; registered.
- out_ready  in  1  decode consumes the beat.
- instr_out  out  INSTR_W  instruction to decode; registered.
- npc_out  out  PC_W  next PC to decode; registered.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of clk; no combinational path from any input to any output.
- Transfer rules:
  - Push = in_valid & in_ready at the edge.
  - Pop = out_valid & out_ready at the edge.
  - Push-to-output latency is 1 cycle when the stage is empty.
- Storage:
  - Main entry (drives outputs) and skid entry; each entry holds instr, npc and a valid bit.
  - State EMPTY: main invalid.
  - State ONE: main valid, skid empty.
  - State FULL: both entries valid.
- in_ready = !skid_valid (registered). It is therefore 1 in EMPTY/ONE and 0 in FULL.
- Reset (rst=1), which has priority over everything:
  - out_valid=0, instr_out=NOP_INSTR, npc_out=0, in_ready=1, skid cleared, state EMPTY.
- Flush (rst=0, flush=1), which has priority over push/pop:
  - Both entries invalidated; out_valid=0, instr_out=NOP_INSTR, npc_out=0; next state EMPTY, in_ready=1.
  - A push coincident with flush is consumed and discarded.
  - A pop coincident with flush counts as consumed.
- Transitions (rst=0, flush=0):
  - EMPTY, push → main loads input → ONE.
  - EMPTY, no push → stays EMPTY.
  - ONE, push & pop → main loads input → stays ONE.
  - ONE, pop only → main gets instr=NOP_INSTR, npc holds, valid=0 → EMPTY.
  - ONE, push only → skid loads input → FULL.
  - ONE, neither → hold.
  - FULL, pop → main loads skid, skid cleared → ONE. No push is possible because in_ready=0.
  - FULL, no pop → hold all.
- Ordering: strictly FIFO; no beat is dropped or duplicated except by flush.
- While out_valid=0, instr_out is always NOP_INSTR, so decode sees a bubble.
- out_ready while out_valid=0 has no effect.
- in_valid while in_ready=0 is ignored; the producer must hold its data.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- No arithmetic; widths pass through unmodified.

Decomposition:
- Shared package `pipe_pkg`:
  - MIPS_NOP constant (32'h0000_0000, sll $0,$0,0).
  - State enum {EMPTY, ONE, FULL}, 2-bit encoding.
  - Default INSTR_W/PC_W localparams, so that ID_EX and later pipe registers reuse them.
- One sub-module is natural: `pipe_entry`, a width-generic data+valid register with load/clear. Instantiate it twice (main, skid).

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 → out_valid=0, instr_out=0x00000000, npc_out=0, in_ready=1. After release, no stale beat appears.
- Streaming: out_ready=1; push instr 0x8C010004/npc 0x04, then 0x20220001/0x08, then 0xAC020008/0x0C on consecutive cycles → each appears on outputs exactly 1 cycle later, in order, with out_valid=1 each cycle.
- Stall/skid: push A(0x8C010004,0x04); drop out_ready; push B(0x20220001,0x08) → FULL, in_ready=0. Hold C(0xAC020008,0x0C) on input for 3 cycles → C not accepted. Raise out_ready → outputs A, B, C in consecutive cycles, no loss.
- Flush in FULL with a coincident push: state FULL, flush=1 with in_valid=1 → next cycle out_valid=0, instr_out=0x00000000, npc_out=0, in_ready=1. The coincident beat never appears.
- Drain to bubble: single push of 0x8C010004/0x04 with out_ready=1, then in_valid=0 → 1 cycle out_valid=1, then out_valid=0 with instr_out=0x00000000.
- Parameter sweep: INSTR_W=64, PC_W=48, NOP_INSTR=64'hFFFF_0000_FFFF_0000 → stall/skid scenario passes, and empty outputs show the NOP pattern.
